// File: rtl/ifetch.sv
// Instruction fetch: in-order request/response fetcher with a small
// instruction buffer, redirect flushing and drop counting of stale responses.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);
    localparam int              PW      = $clog2(DEPTH);
    localparam logic [PW-1:0]   LAST    = PW'(DEPTH - 1);
    localparam logic [4:0]      DEPTH_W = 5'(DEPTH);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    logic [31:2]   fetch_pc_q, fetch_pc_d;
    logic [31:2]   resp_pc_q, resp_pc_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    outst_q, outst_d;
    logic [3:0]    drop_q, drop_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   word_q [DEPTH];

    logic       pop, fire, push;
    logic [4:0] inflight;
    logic       unused_bits;

    assign unused_bits = ^redirect_pc[1:0];

    assign inst_valid = (cnt_q != 4'd0);
    assign inst       = word_q[rd_q];
    assign inst_pc    = pc_q[rd_q];
    assign imem_addr  = {fetch_pc_q, 2'b00};

    assign pop  = inst_valid && inst_ready;
    assign fire = imem_req && imem_gnt;
    assign push = imem_rvalid && (drop_q == 4'd0) && !redirect;

    // Buffer slots are reserved at request time, so the buffer never overflows.
    assign inflight = {1'b0, cnt_q} + {1'b0, outst_q} - {4'b0, pop};
    assign imem_req = !reset && !redirect && (inflight < DEPTH_W);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        drop_d     = drop_q;
        outst_d    = outst_q + {3'b0, fire} - {3'b0, imem_rvalid};
        if (fire)
            fetch_pc_d = fetch_pc_q + 30'd1;
        if (redirect) begin
            fetch_pc_d = redirect_pc[31:2];
            resp_pc_d  = redirect_pc[31:2];
            cnt_d      = 4'd0;
            rd_d       = '0;
            wr_d       = '0;
            drop_d     = outst_d;
        end else begin
            if (imem_rvalid && drop_q != 4'd0)
                drop_d = drop_q - 4'd1;
            if (push) begin
                wr_d      = ptr_inc(wr_q);
                resp_pc_d = resp_pc_q + 30'd1;
            end
            if (pop)
                rd_d = ptr_inc(rd_q);
            cnt_d = cnt_q + {3'b0, push} - {3'b0, pop};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC[31:2];
            resp_pc_q  <= RESET_PC[31:2];
            cnt_q      <= 4'd0;
            outst_q    <= 4'd0;
            drop_q     <= 4'd0;
            rd_q       <= '0;
            wr_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= 32'd0;
                word_q[i] <= 32'd0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            cnt_q      <= cnt_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            if (push) begin
                pc_q[wr_q]   <= {resp_pc_q, 2'b00};
                word_q[wr_q] <= imem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with an in-order fixed-latency memory responder.
module tb_ifetch;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lat = 1;

    typedef struct {
        int          due;
        logic [31:0] a;
    } rq_t;
    rq_t mq[$];

    ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h1357_0000 ^ a;
    endfunction

    always @(negedge clk)
        if (!reset && imem_req && imem_gnt)
            mq.push_back('{cyc + lat, imem_addr});

    always @(posedge clk) begin
        cyc++;
        #1;
        if (reset) begin
            mq.delete();
            imem_rvalid = 1'b0;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem(mq[0].a);
            void'(mq.pop_front());
        end else begin
            imem_rvalid = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int l);
        @(posedge clk); #1;
        reset = 1'b1;
        lat = l;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!inst_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " timeout"}, {31'd0, inst_valid}, 32'd1);
    endtask

    initial begin
        #1;
        chk("rst valid", {31'd0, inst_valid}, 32'd0);
        chk("rst req", {31'd0, imem_req}, 32'd0);
        chk("rst inst", inst, 32'd0);
        chk("rst pc", inst_pc, 32'd0);

        // streaming fetch, 1-cycle memory
        imem_gnt = 1'b1;
        inst_ready = 1'b1;
        do_reset(1);
        @(negedge clk);
        chk("first req", {31'd0, imem_req}, 32'd1);
        chk("first addr", imem_addr, 32'h0);
        @(negedge clk);
        chk("lat not yet", {31'd0, inst_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("seq valid", {31'd0, inst_valid}, 32'd1);
            chk("seq pc", inst_pc, 32'(i * 4));
            chk("seq inst", inst, mem(32'(i * 4)));
        end

        // backpressure fills the buffer
        inst_ready = 1'b0;
        do_reset(1);
        repeat (8) @(negedge clk);
        chk("full req", {31'd0, imem_req}, 32'd0);
        chk("full pc", inst_pc, 32'h0);
        @(negedge clk);
        chk("held pc", inst_pc, 32'h0);
        chk("held inst", inst, mem(32'h0));
        @(posedge clk); #1;
        inst_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("resume pc", inst_pc, 32'(i * 4));
        end

        // grant stall holds address
        imem_gnt = 1'b1;
        do_reset(1);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall req", {31'd0, imem_req}, 32'd1);
            chk("stall addr", imem_addr, 32'h8);
        end
        @(posedge clk); #1;
        imem_gnt = 1'b1;
        @(negedge clk);
        chk("stall grant addr", imem_addr, 32'h8);
        @(negedge clk);
        chk("after grant addr", imem_addr, 32'hC);

        // redirect with two requests in flight
        do_reset(3);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        redirect = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        chk("redir req", {31'd0, imem_req}, 32'd0);
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        chk("redir flush", {31'd0, inst_valid}, 32'd0);
        chk("redir addr", imem_addr, 32'h100);
        wait_valid("redir");
        chk("redir pc", inst_pc, 32'h100);
        chk("redir inst", inst, mem(32'h100));
        @(negedge clk);
        chk("redir next pc", inst_pc, 32'h104);

        // unaligned redirect and address wrap
        imem_gnt = 1'b0;
        do_reset(1);
        redirect = 1'b1;
        redirect_pc = 32'h103;
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        chk("align addr", imem_addr, 32'h100);
        @(posedge clk); #1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        chk("wrap top addr", imem_addr, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        imem_gnt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("wrap addr", imem_addr, 32'h0);
        wait_valid("wrap");
        chk("wrap pc0", inst_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap pc1", inst_pc, 32'h0);

        // asynchronous reset with three entries buffered
        inst_ready = 1'b0;
        do_reset(1);
        repeat (5) @(negedge clk);
        chk("pre-rst valid", {31'd0, inst_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst valid", {31'd0, inst_valid}, 32'd0);
        chk("arst req", {31'd0, imem_req}, 32'd0);
        chk("arst inst", inst, 32'd0);
        chk("arst pc", inst_pc, 32'd0);
        inst_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_valid("post-rst");
        chk("post-rst pc", inst_pc, 32'h0);
        chk("post-rst inst", inst, mem(32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
